// File: rtl/core_multicycle.sv
// Multicycle RV32I/RV64I integer core: single-cycle decode/execute in FETCH,
// handshaked data-memory access in MEM_REQ/MEM_WAIT, and a sticky TRAP state.
module core_multicycle #(
    parameter int              XLEN        = 64,
    parameter int              FETCH_WIDTH = 64,
    parameter int              NREGS       = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [15:0]                      max_instructions_i,
    input  logic                             imem_busy_i,
    input  logic                             imem_rdy_i,
    input  logic [FETCH_WIDTH-1:0]           imem_rd_data_i,
    output logic                             imem_rd_en_o,
    output logic [XLEN-1:0]                  imem_addr_o,
    input  logic                             dmem_busy_i,
    input  logic                             dmem_rdy_i,
    input  logic [FETCH_WIDTH-1:0]           dmem_rd_data_i,
    output logic                             dmem_rd_en_o,
    output logic                             dmem_wr_en_o,
    output logic [XLEN-1:0]                  dmem_addr_o,
    output logic [$clog2(FETCH_WIDTH/8)-1:0] dmem_wr_size_o,
    output logic [FETCH_WIDTH-1:0]           dmem_wr_data_o,
    output logic                             retired_o,
    output logic                             done_o,
    output logic                             trap_o,
    output logic [1:0]                       trap_cause_o,
    input  logic [4:0]                       dbg_rd_addr_i,
    output logic [XLEN-1:0]                  dbg_rd_data_o
);

    localparam int SZW = $clog2(FETCH_WIDTH/8);
    localparam int SHW = $clog2(XLEN);
    localparam int RW  = $clog2(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [1:0] {FETCH, MEM_REQ, MEM_WAIT, TRAP} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] regs [NREGS];
    logic [15:0]     count;
    logic [1:0]      cause;
    logic            retired;
    logic [XLEN-1:0] mem_addr;
    logic [2:0]      mem_f3;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_load;

    logic [31:0]     insn;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            sh_lo, sh_ar;

    logic            illegal, wr_en, jump, is_mem, misaligned;
    logic            use_rd, use_rs1, use_rs2;
    logic [XLEN-1:0] wr_val, next_pc;
    logic            unused_bits;

    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[SHW-1:0];
            3'd2: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'd3: r = {{(XLEN-1){1'b0}}, a < b};
            3'd4: r = a ^ b;
            3'd5: if (alt) r = $signed(a) >>> b[SHW-1:0];
                  else     r = a >> b[SHW-1:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // 32-bit word ops; the result is always sign-extended from bit 31
    function automatic logic [XLEN-1:0] alu_w(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] r;
        case (f3)
            3'd0:    r = alt ? $signed(a - b) : $signed(a + b);
            3'd1:    r = $signed(a << b[4:0]);
            default: if (alt) r = $signed(a) >>> b[4:0];
                     else     r = $signed(a >> b[4:0]);
        endcase
        return XLEN'(r);
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [FETCH_WIDTH-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0:    r = XLEN'($signed(d[7:0]));
            3'd1:    r = XLEN'($signed(d[15:0]));
            3'd2:    r = XLEN'($signed(d[31:0]));
            3'd4:    r = XLEN'(d[7:0]);
            3'd5:    r = XLEN'(d[15:0]);
            3'd6:    r = XLEN'(d[31:0]);
            default: r = d[XLEN-1:0];
        endcase
        return r;
    endfunction

    assign insn   = imem_rd_data_i[FETCH_WIDTH-1 -: 32];
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];

    assign imm_i = XLEN'($signed(insn[31:20]));
    assign imm_s = XLEN'($signed({insn[31:25], insn[11:7]}));
    assign imm_b = XLEN'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({insn[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];

    // The shamt field is one bit wider at XLEN=64, so funct6 replaces funct7
    assign sh_lo = (XLEN == 64) ? (insn[31:26] == 6'b000000) : (insn[31:25] == 7'b0000000);
    assign sh_ar = (XLEN == 64) ? (insn[31:26] == 6'b010000) : (insn[31:25] == 7'b0100000);

    always_comb begin
        illegal = 1'b0;
        wr_en   = 1'b0;
        wr_val  = '0;
        next_pc = pc + XLEN'(4);
        jump    = 1'b0;
        is_mem  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                use_rd = 1'b1; wr_en = 1'b1; wr_val = imm_u;
            end
            OP_AUIPC: begin
                use_rd = 1'b1; wr_en = 1'b1; wr_val = pc + imm_u;
            end
            OP_JAL: begin
                use_rd = 1'b1; wr_en = 1'b1; wr_val = pc + XLEN'(4);
                next_pc = pc + imm_j; jump = 1'b1;
            end
            OP_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1; wr_val = pc + XLEN'(4);
                next_pc = (rs1_val + imm_i) & ~XLEN'(1); jump = 1'b1;
                illegal = (funct3 != 3'd0);
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'd0:    jump = (rs1_val == rs2_val);
                    3'd1:    jump = (rs1_val != rs2_val);
                    3'd4:    jump = ($signed(rs1_val) <  $signed(rs2_val));
                    3'd5:    jump = ($signed(rs1_val) >= $signed(rs2_val));
                    3'd6:    jump = (rs1_val <  rs2_val);
                    3'd7:    jump = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
                if (jump) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
                illegal = (funct3 == 3'd7) ||
                          ((funct3 == 3'd3 || funct3 == 3'd6) && XLEN != 64);
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1;
                illegal = (funct3 > 3'd3) || (funct3 == 3'd3 && XLEN != 64);
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1;
                if (funct3 == 3'd1)      illegal = !sh_lo;
                else if (funct3 == 3'd5) illegal = !(sh_lo || sh_ar);
                wr_val = alu(funct3, funct3 == 3'd5 && insn[30], rs1_val, imm_i);
            end
            OP_REG: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr_en = 1'b1;
                illegal = !(funct7 == 7'b0000000 ||
                            (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
                wr_val = alu(funct3, insn[30], rs1_val, rs2_val);
            end
            OP_IMM32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1;
                illegal = (XLEN != 64) ||
                          !(funct3 == 3'd0 ||
                            (funct3 == 3'd1 && funct7 == 7'b0000000) ||
                            (funct3 == 3'd5 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)));
                wr_val = alu_w(funct3, funct3 == 3'd5 && insn[30], rs1_val[31:0], imm_i[31:0]);
            end
            OP_REG32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr_en = 1'b1;
                illegal = (XLEN != 64) ||
                          !((funct7 == 7'b0000000 &&
                             (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5)) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
                wr_val = alu_w(funct3, insn[30], rs1_val[31:0], rs2_val[31:0]);
            end
            default: illegal = 1'b1;
        endcase
        // Only fields the format actually uses are range-checked (matters for RV32E)
        if ((use_rd  && 32'(rd)  >= NREGS) ||
            (use_rs1 && 32'(rs1) >= NREGS) ||
            (use_rs2 && 32'(rs2) >= NREGS))
            illegal = 1'b1;
    end

    assign misaligned = jump && next_pc[1];

    always_ff @(posedge clk) begin
        retired <= 1'b0;
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            count <= '0;
            cause <= 2'd0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_rdy_i && count < max_instructions_i) begin
                        if (illegal) begin
                            state <= TRAP;
                            cause <= 2'd1;
                        end else if (misaligned) begin
                            state <= TRAP;
                            cause <= 2'd2;
                        end else if (is_mem) begin
                            mem_addr  <= rs1_val + ((opcode == OP_LOAD) ? imm_i : imm_s);
                            mem_f3    <= funct3;
                            mem_rd    <= rd;
                            mem_wdata <= rs2_val;
                            mem_load  <= (opcode == OP_LOAD);
                            state     <= MEM_REQ;
                        end else begin
                            if (wr_en && rd != 5'd0) regs[rd[RW-1:0]] <= wr_val;
                            pc      <= next_pc;
                            count   <= count + 16'd1;
                            retired <= 1'b1;
                        end
                    end
                end
                MEM_REQ: begin
                    if (!dmem_busy_i) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_rdy_i) begin
                        if (mem_load && mem_rd != 5'd0)
                            regs[mem_rd[RW-1:0]] <= load_ext(mem_f3, dmem_rd_data_i);
                        pc      <= pc + XLEN'(4);
                        count   <= count + 16'd1;
                        retired <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by rst so nothing leaks out during the reset cycle
    assign imem_rd_en_o   = !rst && state == FETCH && !imem_busy_i && count < max_instructions_i;
    assign imem_addr_o    = pc;
    assign dmem_rd_en_o   = !rst && state == MEM_REQ && !dmem_busy_i &&  mem_load;
    assign dmem_wr_en_o   = !rst && state == MEM_REQ && !dmem_busy_i && !mem_load;
    assign dmem_addr_o    = mem_addr;
    assign dmem_wr_size_o = mem_f3[SZW-1:0];
    assign dmem_wr_data_o = FETCH_WIDTH'(mem_wdata);
    assign retired_o      = retired && !rst;
    assign done_o         = state == FETCH && count == max_instructions_i;
    assign trap_o         = state == TRAP;
    assign trap_cause_o   = cause;

    assign dbg_rd_data_o  = (dbg_rd_addr_i == 5'd0 || 32'(dbg_rd_addr_i) >= NREGS)
                            ? '0 : regs[dbg_rd_addr_i[RW-1:0]];

    assign unused_bits = ^{imem_rd_data_i, dmem_rd_data_i, mem_f3, mem_rd};

endmodule

// File: tb/tb_core_multicycle.sv
// Directed bench for core_multicycle (XLEN=64): ALU/W-ops, loads with busy
// back-pressure, branches/jumps, traps, reset during MEM_WAIT and retire limit.
module tb_core_multicycle;

    logic        clk;
    logic        rst;
    logic [15:0] max_instructions_i;
    logic        imem_busy_i;
    logic        imem_rdy_i;
    logic [63:0] imem_rd_data_i;
    logic        imem_rd_en_o;
    logic [63:0] imem_addr_o;
    logic        dmem_busy_i;
    logic        dmem_rdy_i;
    logic [63:0] dmem_rd_data_i;
    logic        dmem_rd_en_o;
    logic        dmem_wr_en_o;
    logic [63:0] dmem_addr_o;
    logic [2:0]  dmem_wr_size_o;
    logic [63:0] dmem_wr_data_o;
    logic        retired_o;
    logic        done_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;
    logic [4:0]  dbg_rd_addr_i;
    logic [63:0] dbg_rd_data_o;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;

    core_multicycle dut (
        .clk                (clk),
        .rst                (rst),
        .max_instructions_i (max_instructions_i),
        .imem_busy_i        (imem_busy_i),
        .imem_rdy_i         (imem_rdy_i),
        .imem_rd_data_i     (imem_rd_data_i),
        .imem_rd_en_o       (imem_rd_en_o),
        .imem_addr_o        (imem_addr_o),
        .dmem_busy_i        (dmem_busy_i),
        .dmem_rdy_i         (dmem_rdy_i),
        .dmem_rd_data_i     (dmem_rd_data_i),
        .dmem_rd_en_o       (dmem_rd_en_o),
        .dmem_wr_en_o       (dmem_wr_en_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wr_size_o     (dmem_wr_size_o),
        .dmem_wr_data_o     (dmem_wr_data_o),
        .retired_o          (retired_o),
        .done_o             (done_o),
        .trap_o             (trap_o),
        .trap_cause_o       (trap_cause_o),
        .dbg_rd_addr_i      (dbg_rd_addr_i),
        .dbg_rd_data_o      (dbg_rd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (retired_o === 1'b1) pulses <= pulses + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        imem_rdy_i     = 1'b1;
        imem_rd_data_i = {ins, 32'h0};
        step();
        imem_rdy_i     = 1'b0;
        imem_rd_data_i = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
        dbg_rd_addr_i = idx;
        #1;
        check(tag, dbg_rd_data_o, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; max_instructions_i = 16'd100;
        imem_busy_i = 1'b0; imem_rdy_i = 1'b0; imem_rd_data_i = '0;
        dmem_busy_i = 1'b0; dmem_rdy_i = 1'b0; dmem_rd_data_i = '0;
        dbg_rd_addr_i = '0;
        #1;
        check("rst_cycle_imem_en", {63'd0, imem_rd_en_o}, 64'd0);
        check("rst_cycle_retired", {63'd0, retired_o}, 64'd0);
        check("rst_cycle_dmem_rd", {63'd0, dmem_rd_en_o}, 64'd0);
        do_reset();
        check("rst_pc", imem_addr_o, 64'h0);
        check("rst_trap", {62'd0, trap_o, 1'b0} | {62'd0, trap_cause_o}, 64'd0);
        chk_reg("rst_x1", 5'd1, 64'd0);
        check("post_rst_fetch_en", {63'd0, imem_rd_en_o}, 64'd1);

        // 1: ADDI x1,x0,-1
        p0 = pulses;
        issue(32'hFFF00093);
        check("t1_retired", {63'd0, retired_o}, 64'd1);
        check("t1_pc", imem_addr_o, 64'h4);
        chk_reg("t1_x1", 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("t1_retired_clear", {63'd0, retired_o}, 64'd0);
        check("t1_one_pulse", 64'(pulses - p0), 64'd1);

        // 2: x0 write discarded; ADDIW sign-extension; SRAI
        issue(32'h00500013);
        chk_reg("t2_x0", 5'd0, 64'd0);
        issue(32'h00100093);
        issue(32'h01F09093);
        chk_reg("t2_x1_slli", 5'd1, 64'h0000_0000_8000_0000);
        issue(32'h0000811B);
        chk_reg("t2_x2_addiw", 5'd2, 64'hFFFF_FFFF_8000_0000);
        issue(32'h40415293);
        chk_reg("t2_x5_srai", 5'd5, 64'hFFFF_FFFF_F800_0000);
        check("t2_pc", imem_addr_o, 64'h18);

        // 3: LB x3,16(x0) with 3 busy cycles, then LBU
        dmem_busy_i = 1'b1;
        issue(32'h01000183);
        check("t3_fetch_off_in_mem", {63'd0, imem_rd_en_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t3_busy_holdoff", {63'd0, dmem_rd_en_o}, 64'd0);
            if (i < 2) step();
        end
        dmem_busy_i = 1'b0;
        #1;
        check("t3_rd_en", {63'd0, dmem_rd_en_o}, 64'd1);
        check("t3_addr", dmem_addr_o, 64'h10);
        step();
        check("t3_wait_rd_en_low", {63'd0, dmem_rd_en_o}, 64'd0);
        dmem_rdy_i = 1'b1; dmem_rd_data_i = 64'h80;
        step();
        dmem_rdy_i = 1'b0;
        check("t3_lb_retired", {63'd0, retired_o}, 64'd1);
        chk_reg("t3_lb_x3", 5'd3, 64'hFFFF_FFFF_FFFF_FF80);
        check("t3_lb_pc", imem_addr_o, 64'h1C);
        issue(32'h01004183);
        step();
        dmem_rdy_i = 1'b1;
        step();
        dmem_rdy_i = 1'b0;
        chk_reg("t3_lbu_x3", 5'd3, 64'h80);

        // 4: branch back, JAL, JALR, misaligned JAL
        do_reset();
        issue(32'h00000013);
        issue(32'h00000013);
        issue(32'hFE000CE3);
        check("t4_beq_pc", imem_addr_o, 64'h0);
        for (int i = 0; i < 4; i++) issue(32'h00000013);
        issue(32'h010000EF);
        chk_reg("t4_jal_x1", 5'd1, 64'h14);
        check("t4_jal_pc", imem_addr_o, 64'h20);
        issue(32'h041003E7);
        chk_reg("t4_jalr_x7", 5'd7, 64'h24);
        check("t4_jalr_pc", imem_addr_o, 64'h40);
        issue(32'h0020006F);
        check("t4_mis_trap", {63'd0, trap_o}, 64'd1);
        check("t4_mis_cause", {62'd0, trap_cause_o}, 64'd2);
        check("t4_mis_pc", imem_addr_o, 64'h40);
        check("t4_mis_no_retire", {63'd0, retired_o}, 64'd0);

        // 5: illegal opcode, then reset clears trap
        do_reset();
        check("t5_rst_trap", {63'd0, trap_o}, 64'd0);
        check("t5_rst_pc", imem_addr_o, 64'h0);
        issue(32'h0000007F);
        check("t5_ill_trap", {63'd0, trap_o}, 64'd1);
        check("t5_ill_cause", {62'd0, trap_cause_o}, 64'd1);
        step();
        check("t5_ill_fetch_off", {63'd0, imem_rd_en_o}, 64'd0);
        check("t5_ill_pc", imem_addr_o, 64'h0);

        // 6: reset during MEM_WAIT, late dmem_rdy, then run to the retire limit
        do_reset();
        max_instructions_i = 16'd3;
        check("t6_rst_trap", {63'd0, trap_o}, 64'd0);
        issue(32'hFFF00093);
        issue(32'h00102023);
        check("t6_sw_wr_en", {63'd0, dmem_wr_en_o}, 64'd1);
        check("t6_sw_rd_en", {63'd0, dmem_rd_en_o}, 64'd0);
        check("t6_sw_size", {61'd0, dmem_wr_size_o}, 64'd2);
        check("t6_sw_data", dmem_wr_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_sw_addr", dmem_addr_o, 64'h0);
        step();
        check("t6_wait_wr_low", {63'd0, dmem_wr_en_o}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_rdy_i = 1'b1; dmem_rd_data_i = 64'h1234;
        step();
        dmem_rdy_i = 1'b0;
        check("t6_late_pc", imem_addr_o, 64'h0);
        check("t6_late_no_retire", {63'd0, retired_o}, 64'd0);
        chk_reg("t6_late_x1", 5'd1, 64'd0);
        issue(32'hFFF00093);
        issue(32'h00102023);
        step();
        dmem_rdy_i = 1'b1;
        step();
        dmem_rdy_i = 1'b0;
        check("t6_sw_retired", {63'd0, retired_o}, 64'd1);
        check("t6_sw_pc", imem_addr_o, 64'h8);
        check("t6_not_done", {63'd0, done_o}, 64'd0);
        issue(32'h00700113);
        chk_reg("t6_x2", 5'd2, 64'd7);
        check("t6_done", {63'd0, done_o}, 64'd1);
        check("t6_done_fetch_off", {63'd0, imem_rd_en_o}, 64'd0);
        issue(32'h00900113);
        chk_reg("t6_limit_x2", 5'd2, 64'd7);
        check("t6_limit_pc", imem_addr_o, 64'hC);
        max_instructions_i = 16'd4;
        #1;
        check("t6_resume_done", {63'd0, done_o}, 64'd0);
        check("t6_resume_fetch", {63'd0, imem_rd_en_o}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
